// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache line refills (multi-beat reads)
// and single-word LSU accesses, with tie arbitration and a saturating conflict counter.
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter bit D_PRIORITY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic [31:0]                   i_rdata,
  output logic                          i_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] i_beat,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  input  logic [3:0]                    d_wstrb,
  output logic [31:0]                   d_rdata,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic [3:0]                    mem_wstrb,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [31:0]                   conflict_count
);
  typedef enum logic [1:0] {IDLE, I_BURST, D_ACC, DONE} state_t;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  state_t state_q;
  logic last_d_q;
  logic [$clog2(LINE_WORDS)-1:0] beat_q;
  logic grant_d, grant_i, beat_done, conflict;
  logic [31:0] conflict_d;
  // D wins a tie under fixed priority, or when I owned the port last
  assign grant_d = d_req & (~i_req | D_PRIORITY | ~last_d_q);
  assign grant_i = i_req & ~grant_d;
  assign beat_done = mem_req & mem_ready;
  assign conflict = (state_q == IDLE && i_req && d_req) ||
                    (state_q == I_BURST && d_req) ||
                    (state_q == D_ACC && i_req) ||
                    (state_q == DONE && (last_d_q ? i_req : d_req));
  assign conflict_d = (conflict && !(&conflict_count)) ? conflict_count + 32'd1 : conflict_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_d_q       <= 1'b0;
      beat_q         <= '0;
      i_rdata        <= '0;
      i_rvalid       <= 1'b0;
      i_beat         <= '0;
      i_done         <= 1'b0;
      d_rdata        <= '0;
      d_done         <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      busy           <= 1'b0;
      conflict_count <= '0;
    end else begin
      i_rvalid       <= 1'b0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      conflict_count <= conflict_d;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q   <= D_ACC;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_we ? d_wstrb : 4'h0;
          end else if (grant_i) begin
            state_q   <= I_BURST;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr & ~LINE_MASK;
            mem_wstrb <= 4'h0;
            beat_q    <= '0;
          end
        end
        I_BURST: begin
          if (beat_done) begin
            i_rvalid <= 1'b1;
            i_rdata  <= mem_rdata;
            i_beat   <= beat_q;
            beat_q   <= beat_q + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (&beat_q) begin
              mem_req  <= 1'b0;
              state_q  <= DONE;
              i_done   <= 1'b1;
              last_d_q <= 1'b0;
            end
          end
        end
        D_ACC: begin
          if (beat_done) begin
            mem_req  <= 1'b0;
            state_q  <= DONE;
            d_done   <= 1'b1;
            d_rdata  <= mem_we ? 32'h0 : mem_rdata;
            last_d_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected memory beats, refill beats and D completions
// are queued by the stimulus thread and retired by a negedge monitor.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, i_req, i_rvalid, i_done, d_req, d_we, d_done, mem_req, mem_we, mem_ready, busy;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata, conflict_count;
  logic [1:0] i_beat;
  logic [3:0] d_wstrb, mem_wstrb;
  logic i_req1, d_req1, i_rvalid1, i_done1, d_done1, mem_req1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, conflict_count1;
  logic [1:0] i_beat1;
  logic [3:0] mem_wstrb1;
  logic mem_ready1;
  logic [31:0] mem_rdata1;
  assign mem_ready1 = 1'b1;
  assign mem_rdata1 = 32'h0;
  mem_arbiter #(.LINE_WORDS(4), .D_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_rvalid(i_rvalid), .i_beat(i_beat), .i_done(i_done), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
    .conflict_count(conflict_count));
  mem_arbiter #(.LINE_WORDS(4), .D_PRIORITY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .i_req(i_req1), .i_addr(i_addr), .i_rdata(i_rdata1),
    .i_rvalid(i_rvalid1), .i_beat(i_beat1), .i_done(i_done1), .d_req(d_req1), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata1), .d_done(d_done1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .busy(busy1),
    .conflict_count(conflict_count1));
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mem_t;
  mem_t memq[$];
  logic [31:0] dq[$];
  logic [34:0] iq[$];
  bit pat[$];
  int tests = 0, fails = 0, req_cycles = 0;
  function automatic logic [31:0] mdl(input logic [31:0] a);
    return (a == 32'h200) ? 32'hCAFEF00D : a ^ 32'h5A5A0000;
  endfunction
  assign mem_rdata = mem_ready ? mdl(mem_addr) : 32'hBAD0BAD0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask
  task automatic unexp(input string n);
    tests++;
    fails++;
    $display("FAIL %s: event with no expected entry or wait expired", n);
  endtask
  task automatic push_d(input logic we, input logic [31:0] a, w, input logic [3:0] s, input logic [31:0] r);
    memq.push_back('{we, a, w, we ? s : 4'h0});
    dq.push_back(r);
  endtask
  task automatic push_line(input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      memq.push_back('{1'b0, base + 32'(4 * b), 32'h0, 4'h0});
      iq.push_back({b == 3, 2'(b), mdl(base + 32'(4 * b))});
    end
  endtask
  task automatic d_go(input logic we, input logic [31:0] a, w, input logic [3:0] s, output int lat);
    d_we = we; d_addr = a; d_wdata = w; d_wstrb = s; d_req = 1'b1;
    for (lat = 0; lat < 200; lat++) begin
      @(negedge clk);
      if (d_done) break;
    end
    if (lat == 200) unexp("d_timeout");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask
  task automatic i_go(input logic [31:0] a, output int lat);
    i_addr = a; i_req = 1'b1;
    for (lat = 0; lat < 200; lat++) begin
      @(negedge clk);
      if (i_done) break;
    end
    if (lat == 200) unexp("i_timeout");
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask
  // memory model: wait-state pattern is consumed only on cycles with an outstanding request
  always @(posedge clk) begin
    #1;
    mem_ready = (mem_req && reset) ? ((pat.size() > 0) ? pat.pop_front() : 1'b1) : 1'b0;
  end
  always @(negedge clk) begin
    if (reset) begin
      if (mem_req) begin
        req_cycles++;
        if (memq.size() == 0) unexp("mem_req_extra");
        else begin
          chk("mem_we", mem_we, memq[0].we);
          chk("mem_addr", mem_addr, memq[0].addr);
          chk("mem_wstrb", mem_wstrb, memq[0].wstrb);
          if (memq[0].we) chk("mem_wdata", mem_wdata, memq[0].wdata);
          if (mem_ready) void'(memq.pop_front());
        end
      end
      if (d_done) begin
        if (dq.size() == 0) unexp("d_done_extra");
        else chk("d_rdata", d_rdata, dq.pop_front());
      end
      if (i_rvalid) begin
        if (iq.size() == 0) unexp("i_rvalid_extra");
        else chk("i_done_beat_data", {i_done, i_beat, i_rdata}, iq.pop_front());
      end else if (i_done) unexp("i_done_without_beat");
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int lat, lat2;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; i_req1 = 1'b0; d_req1 = 1'b0;
    d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", {busy, busy1}, 0);
    chk("rst_conflict", conflict_count, 0);
    chk("rst_pulses", {i_done, d_done, i_rvalid}, 0);
    chk("rst_addr_beat", {mem_addr, i_beat}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    push_d(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0);
    req_cycles = 0;
    d_go(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat);
    chk("d_wr_latency", lat, 2);
    chk("d_wr_req_cycles", req_cycles, 1);
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    push_line(32'h1230);
    i_go(32'h1234, lat);
    chk("i_refill_latency", lat, 6);
    chk("i_refill_beats_left", iq.size(), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_d(1'b1, 32'h300, 32'h11112222, 4'h3, 32'h0);
    push_line(32'h400);
    fork
      d_go(1'b1, 32'h300, 32'h11112222, 4'h3, lat);
      i_go(32'h408, lat2);
    join
    chk("tie1_conflict", conflict_count, 3);
    chk("tie1_i_latency", lat2, 8);
    push_d(1'b0, 32'h304, 32'h0, 4'hF, mdl(32'h304));
    push_line(32'h500);
    fork
      d_go(1'b0, 32'h304, 32'h0, 4'hF, lat);
      i_go(32'h500, lat2);
    join
    chk("tie2_conflict", conflict_count, 6);
    chk("tie2_d_latency", lat, 2);
    i_req1 = 1'b1; d_req1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("prio_busy", busy1, k % 3 != 0);
      chk("prio_d_done", d_done1, k % 3 == 2);
      chk("prio_no_i", i_rvalid1, 0);
    end
    @(posedge clk); #1;
    d_req1 = 1'b0;
    for (lat = 0; lat < 200; lat++) begin
      @(negedge clk);
      if (i_done1) break;
    end
    if (lat == 200) unexp("prio_i_timeout");
    @(posedge clk); #1;
    i_req1 = 1'b0;
    chk("prio_conflict", conflict_count1, 9);
    memq.push_back('{1'b0, 32'h600, 32'h0, 4'h0});
    memq.push_back('{1'b0, 32'h604, 32'h0, 4'h0});
    iq.push_back({1'b0, 2'd0, mdl(32'h600)});
    i_addr = 32'h600; i_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0; i_req = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_rvalid", i_rvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_pending", memq.size() + iq.size(), 0);
    push_line(32'h600);
    i_go(32'h600, lat);
    chk("restart_latency", lat, 5);
    pat = '{1'b0, 1'b0, 1'b0, 1'b1};
    push_d(1'b0, 32'h200, 32'h55, 4'hF, 32'hCAFEF00D);
    d_go(1'b0, 32'h200, 32'h55, 4'hF, lat);
    chk("d_rd_wait_latency", lat, 5);
    chk("queues_empty", memq.size() + dq.size() + iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
